pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
Program-counter and fetch-sequencing stage for the single-cycle core.
- Consumes the 10-bit branch target produced by the target lookup table.
- Computes the next instruction address as sequential, absolute-jump or PC-relative.
- Runs a start/halt handshake with the testbench/top level and counts retired instructions.
- Sits between the decode/branch logic and the instruction ROM address input.

Parameters:
PC_W, 10, width of program counter, Target and StartAddr
START_ADDR, 0, PC value loaded on reset
CNT_W, 16, width of retired-instruction counter

Ports:
Clk  input  1  system clock, rising-edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  single-cycle request to begin execution at StartAddr; honoured only in IDLE or DONE
StartAddr  input  PC_W  program entry address
Stall  input  1  hold PC and counter this cycle
BranchEn  input  1  taken branch/jump for the instruction at PC
BranchRel  input  1  1: next PC = PC + Target (two's complement); 0: next PC = Target
Target  input  PC_W  branch target/offset from lookup table
Halt  input  1  decoded halt instruction at current PC
PC  output  PC_W  current instruction address (registered)
Running  output  1  high while in RUN
Done  output  1  high while in DONE
InstCount  output  CNT_W  instructions retired since last Start

Behaviour:
Clock and reset:
- One clock (Clk). Reset is asynchronous and active-high.
- Reset forces state=IDLE, PC=START_ADDR, InstCount=0, Running=0, Done=0 immediately, independent of Clk.
- All outputs are registered or decoded from registered state only. No combinational input-to-output paths.

State machine (IDLE, RUN, DONE):
- IDLE: Start=1 -> PC<=StartAddr, InstCount<=0, state<=RUN. All other inputs ignored.
- RUN: per-cycle priority is Stall > Halt > BranchEn > sequential.
  - Stall=1: PC, InstCount and state held.
  - Halt=1: PC held, InstCount+1, state<=DONE.
  - BranchEn=1, BranchRel=0: PC<=Target.
  - BranchEn=1, BranchRel=1: PC<=PC+Target.
  - Otherwise: PC<=PC+1.
  - Every non-stalled RUN cycle increments InstCount.
  - Start is ignored in RUN; no restart mid-program.
- DONE: PC and InstCount held. Start=1 -> PC<=StartAddr, InstCount<=0, state<=RUN. Done falls and Running rises on the same edge.

Arithmetic and width rules:
- All PC arithmetic is modulo 2^PC_W; wrap-around is silent.
- Relative Target is interpreted as signed PC_W-bit.
- InstCount saturates at all-ones and does not wrap.

Output timing:
- Running = (state==RUN); Done = (state==DONE).
- Done asserts on the first cycle after the edge that sampled Halt.

Boundary conditions:
- Halt together with BranchEn: Halt wins; no jump.
- Stall together with Halt: nothing happens that cycle; Halt re-evaluated next cycle.
- Reset asserted mid-RUN: immediate return to IDLE with reset values. A Start coincident with Reset deassertion is not honoured until the next rising edge after Reset is low.

Test Plan:
- Reset, Start with StartAddr=0x014, run 3 cycles with no branch -> PC 0x014, 0x015, 0x016, 0x017; Running=1; InstCount=3.
- At PC=0x014, BranchEn=1, BranchRel=1, Target=0x3F0 -> next PC=0x004. Then BranchRel=0, Target=0x007 -> next PC=0x007.
- Wrap: PC=0x3FF sequential -> 0x000. PC=0x3FF, relative Target=0x003 -> 0x002.
- Halt with BranchEn=1, Target=0x001 at PC=0x010 -> PC stays 0x010; Done=1, Running=0 next cycle; InstCount increments by 1. Then Start with StartAddr=0x020 -> PC=0x020, InstCount=0, Running=1.
- Stall=1 and Halt=1 for 2 cycles, then Stall=0 -> PC and InstCount frozen for 2 cycles; DONE entered only after Stall drops.
- Assert Reset asynchronously mid-RUN at PC=0x055 (between edges) -> PC=START_ADDR, InstCount=0, Running=0 immediately; Start while in RUN -> ignored, PC keeps incrementing.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch sequencer: IDLE/RUN/DONE control with sequential,
// absolute and PC-relative next-address selection and a saturating retire counter.
module pc_fetch_ctrl #(
    parameter int unsigned PC_W       = 10,
    parameter logic [PC_W-1:0] START_ADDR = '0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [PC_W-1:0]  StartAddr,
    input  logic             Stall,
    input  logic             BranchEn,
    input  logic             BranchRel,
    input  logic [PC_W-1:0]  Target,
    input  logic             Halt,
    output logic [PC_W-1:0]  PC,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] InstCount
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    // Retire counter sticks at all-ones instead of wrapping.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path
        // through the case below can leave one unassigned and infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    pc_d    = StartAddr;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Stall beats Halt beats branch beats sequential; Start is ignored here.
                if (!Stall) begin
                    cnt_d = cnt_inc;
                    if (Halt) begin
                        state_d = ST_DONE;
                    end else if (BranchEn) begin
                        pc_d = BranchRel ? pc_q + Target : Target;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            pc_q    <= START_ADDR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign PC        = pc_q;
    assign InstCount = cnt_q;
    assign Running   = (state_q == ST_RUN);
    assign Done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: a vector table for the per-cycle behaviour
// plus a hand-written asynchronous reset sequence; a narrow-counter copy shows saturation.
module tb_pc_fetch_ctrl;

    localparam int PC_W  = 10;
    localparam int CNT_W = 16;
    localparam int SAT_W = 3;

    logic             Clk;
    logic             Reset;
    logic             Start;
    logic [PC_W-1:0]  StartAddr;
    logic             Stall;
    logic             BranchEn;
    logic             BranchRel;
    logic [PC_W-1:0]  Target;
    logic             Halt;
    logic [PC_W-1:0]  PC;
    logic             Running;
    logic             Done;
    logic [CNT_W-1:0] InstCount;

    logic [PC_W-1:0]  sat_pc;
    logic             sat_running;
    logic             sat_done;
    logic [SAT_W-1:0] sat_count;

    pc_fetch_ctrl u_dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .StartAddr (StartAddr),
        .Stall     (Stall),
        .BranchEn  (BranchEn),
        .BranchRel (BranchRel),
        .Target    (Target),
        .Halt      (Halt),
        .PC        (PC),
        .Running   (Running),
        .Done      (Done),
        .InstCount (InstCount)
    );

    pc_fetch_ctrl #(.CNT_W(SAT_W)) u_sat (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .StartAddr (StartAddr),
        .Stall     (Stall),
        .BranchEn  (BranchEn),
        .BranchRel (BranchRel),
        .Target    (Target),
        .Halt      (Halt),
        .PC        (sat_pc),
        .Running   (sat_running),
        .Done      (sat_done),
        .InstCount (sat_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic             start;
        logic [PC_W-1:0]  start_addr;
        logic             stall;
        logic             br_en;
        logic             br_rel;
        logic [PC_W-1:0]  target;
        logic             halt;
        logic [PC_W-1:0]  exp_pc;
        logic             exp_running;
        logic             exp_done;
        logic [CNT_W-1:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   failures;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic add(input logic st, input logic [PC_W-1:0] sa, input logic stl,
                       input logic be, input logic br, input logic [PC_W-1:0] tg,
                       input logic hl, input logic [PC_W-1:0] epc, input logic er,
                       input logic ed, input logic [CNT_W-1:0] ec);
        vec_t v;
        v.start = st; v.start_addr = sa; v.stall = stl; v.br_en = be; v.br_rel = br;
        v.target = tg; v.halt = hl; v.exp_pc = epc; v.exp_running = er;
        v.exp_done = ed; v.exp_cnt = ec;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        Start = 0; StartAddr = '0; Stall = 0; BranchEn = 0; BranchRel = 0; Target = '0; Halt = 0;
    endtask

    function automatic logic [SAT_W-1:0] sat_of(input logic [CNT_W-1:0] c);
        return (c > CNT_W'(7)) ? SAT_W'(7) : c[SAT_W-1:0];
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        Reset    = 1'b1;
        idle_inputs();

        //   st sa      stl be br tg      hl  exp_pc  run done cnt
        add(0, 10'h3AA, 0, 1, 0, 10'h155, 1, 10'h000, 0, 0, 0);   // IDLE ignores all but Start
        add(1, 10'h014, 0, 0, 0, 10'h000, 0, 10'h014, 1, 0, 0);
        add(0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h015, 1, 0, 1);
        add(0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h016, 1, 0, 2);
        add(0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h017, 1, 0, 3);
        add(0, 10'h000, 0, 1, 1, 10'h3FD, 0, 10'h014, 1, 0, 4);   // -3 back to 0x014
        add(0, 10'h000, 0, 1, 1, 10'h3F0, 0, 10'h004, 1, 0, 5);
        add(0, 10'h000, 0, 1, 0, 10'h007, 0, 10'h007, 1, 0, 6);
        add(0, 10'h000, 0, 1, 0, 10'h3FF, 0, 10'h3FF, 1, 0, 7);
        add(0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h000, 1, 0, 8);   // sequential wrap
        add(0, 10'h000, 0, 1, 0, 10'h3FF, 0, 10'h3FF, 1, 0, 9);
        add(0, 10'h000, 0, 1, 1, 10'h003, 0, 10'h002, 1, 0, 10);  // relative wrap
        add(0, 10'h000, 0, 1, 0, 10'h010, 0, 10'h010, 1, 0, 11);
        add(0, 10'h000, 0, 1, 0, 10'h001, 1, 10'h010, 0, 1, 12);  // Halt beats branch
        add(0, 10'h000, 1, 1, 0, 10'h2AA, 1, 10'h010, 0, 1, 12);  // DONE holds
        add(1, 10'h020, 0, 0, 0, 10'h000, 0, 10'h020, 1, 0, 0);
        add(0, 10'h000, 1, 0, 0, 10'h000, 1, 10'h020, 1, 0, 0);   // Stall beats Halt
        add(0, 10'h000, 1, 0, 0, 10'h000, 1, 10'h020, 1, 0, 0);
        add(0, 10'h000, 0, 0, 0, 10'h000, 1, 10'h020, 0, 1, 1);
        add(1, 10'h050, 0, 0, 0, 10'h000, 0, 10'h050, 1, 0, 0);
        add(0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h051, 1, 0, 1);
        add(0, 10'h000, 1, 1, 0, 10'h3AA, 0, 10'h051, 1, 0, 1);
        add(0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h052, 1, 0, 2);
        add(0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h053, 1, 0, 3);
        add(1, 10'h123, 0, 0, 0, 10'h000, 0, 10'h054, 1, 0, 4);   // Start ignored in RUN
        add(0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h055, 1, 0, 5);

        // Asynchronous reset state before any clock edge.
        #2;
        check("rst_pc", 32'(PC), 32'h0);
        check("rst_running", 32'(Running), 32'h0);
        check("rst_done", 32'(Done), 32'h0);
        check("rst_cnt", 32'(InstCount), 32'h0);

        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;

        foreach (vecs[i]) begin
            Start     = vecs[i].start;
            StartAddr = vecs[i].start_addr;
            Stall     = vecs[i].stall;
            BranchEn  = vecs[i].br_en;
            BranchRel = vecs[i].br_rel;
            Target    = vecs[i].target;
            Halt      = vecs[i].halt;
            @(posedge Clk);
            #1;
            check($sformatf("v%0d_pc", i), 32'(PC), 32'(vecs[i].exp_pc));
            check($sformatf("v%0d_running", i), 32'(Running), 32'(vecs[i].exp_running));
            check($sformatf("v%0d_done", i), 32'(Done), 32'(vecs[i].exp_done));
            check($sformatf("v%0d_cnt", i), 32'(InstCount), 32'(vecs[i].exp_cnt));
            check($sformatf("v%0d_sat_cnt", i), 32'(sat_count), 32'(sat_of(vecs[i].exp_cnt)));
        end

        // Reset mid-RUN at PC=0x055, between edges: must act without a clock.
        idle_inputs();
        #3;
        Reset = 1'b1;
        #1;
        check("midrun_rst_pc", 32'(PC), 32'h0);
        check("midrun_rst_cnt", 32'(InstCount), 32'h0);
        check("midrun_rst_running", 32'(Running), 32'h0);
        check("midrun_rst_done", 32'(Done), 32'h0);
        check("midrun_rst_sat_cnt", 32'(sat_count), 32'h0);

        // Start while Reset is still high is not honoured.
        Start     = 1'b1;
        StartAddr = 10'h033;
        @(posedge Clk);
        #1;
        check("start_in_rst_pc", 32'(PC), 32'h0);
        check("start_in_rst_running", 32'(Running), 32'h0);

        Reset = 1'b0;
        @(posedge Clk);
        #1;
        check("start_after_rst_pc", 32'(PC), 32'h033);
        check("start_after_rst_running", 32'(Running), 32'h1);
        check("start_after_rst_cnt", 32'(InstCount), 32'h0);

        idle_inputs();
        @(posedge Clk);
        #1;
        check("seq_after_rst_pc", 32'(PC), 32'h034);
        check("seq_after_rst_cnt", 32'(InstCount), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
